// File: rtl/branch_resolve_ctrl.sv
// ID-stage branch resolution sequencer: stalls the front end on RAW hazards
// against EX/MEM, then issues the PC redirect and IF/ID flush when the branch resolves.
module branch_resolve_ctrl #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned CNT_W     = 32,
  parameter logic [6:0]  BR_OPCODE = 7'b1100011
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             kill,
  input  logic             id_valid,
  input  logic [6:0]       id_opcode,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_imm,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             mem_mem_read,
  input  logic [4:0]       mem_rd,
  input  logic             branch_taken,
  output logic             stall_front,
  output logic             bubble_id_ex,
  output logic             pc_redirect,
  output logic             flush_if_id,
  output logic [XLEN-1:0]  branch_target,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] taken_count,
  output logic [CNT_W-1:0] stall_count,
  output logic [1:0]       dbg_state,
  output logic             dbg_cnt
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_STALL   = 2'd1,
    S_RESOLVE = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   cnt_q, cnt_d;

  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] tk_cnt_q, tk_cnt_d;
  logic [CNT_W-1:0] st_cnt_q, st_cnt_d;

  logic       is_br;
  logic       load_ex1, alu_ex1, load_mem1;
  logic       load_ex2, alu_ex2, load_mem2;
  logic [1:0] need1, need2, need_max;
  logic       stall_c, resolve_c;

  assign is_br = id_valid && (id_opcode == BR_OPCODE);

  // Per-operand stall requirement; x0 never creates a dependency.
  always_comb begin
    load_ex1  = (id_rs1 != 5'd0) && ex_mem_read && (ex_rd == id_rs1);
    alu_ex1   = (id_rs1 != 5'd0) && ex_reg_write && !ex_mem_read && (ex_rd == id_rs1);
    load_mem1 = (id_rs1 != 5'd0) && mem_mem_read && (mem_rd == id_rs1);
    load_ex2  = (id_rs2 != 5'd0) && ex_mem_read && (ex_rd == id_rs2);
    alu_ex2   = (id_rs2 != 5'd0) && ex_reg_write && !ex_mem_read && (ex_rd == id_rs2);
    load_mem2 = (id_rs2 != 5'd0) && mem_mem_read && (mem_rd == id_rs2);
    need1     = load_ex1 ? 2'd2 : ((alu_ex1 || load_mem1) ? 2'd1 : 2'd0);
    need2     = load_ex2 ? 2'd2 : ((alu_ex2 || load_mem2) ? 2'd1 : 2'd0);
    need_max  = (need1 > need2) ? need1 : need2;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_c   = 1'b0;
    resolve_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (is_br) begin
          if (need_max != 2'd0) begin
            stall_c = 1'b1;
            cnt_d   = 1'b0;
            state_d = (need_max == 2'd2) ? S_STALL : S_RESOLVE;
          end else begin
            resolve_c = 1'b1;
          end
        end
      end
      S_STALL: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        state_d = S_RESOLVE;
      end
      S_RESOLVE: begin
        resolve_c = 1'b1;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 1'b0;
      end
    endcase

    // A frozen pipeline keeps stalling but must not take the redirect.
    if (hold) begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      resolve_c = 1'b0;
    end

    if (kill || rst) begin
      state_d   = S_IDLE;
      cnt_d     = 1'b0;
      stall_c   = 1'b0;
      resolve_c = 1'b0;
    end
  end

  assign stall_front   = stall_c;
  assign bubble_id_ex  = stall_c;
  assign pc_redirect   = resolve_c && branch_taken;
  assign flush_if_id   = resolve_c && branch_taken;
  assign branch_target = id_pc + id_imm;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != {CNT_W{1'b1}})) return v + 1'b1;
    return v;
  endfunction

  // stall_c/resolve_c are already zero under kill, so only hold needs gating here.
  always_comb begin
    br_cnt_d = br_cnt_q;
    tk_cnt_d = tk_cnt_q;
    st_cnt_d = st_cnt_q;
    if (!hold) begin
      br_cnt_d = sat_inc(br_cnt_q, resolve_c);
      tk_cnt_d = sat_inc(tk_cnt_q, resolve_c && branch_taken);
      st_cnt_d = sat_inc(st_cnt_q, stall_c);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 1'b0;
      br_cnt_q <= '0;
      tk_cnt_q <= '0;
      st_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      br_cnt_q <= br_cnt_d;
      tk_cnt_q <= tk_cnt_d;
      st_cnt_q <= st_cnt_d;
    end
  end

  assign br_count    = br_cnt_q;
  assign taken_count = tk_cnt_q;
  assign stall_count = st_cnt_q;
  assign dbg_state   = state_q;
  assign dbg_cnt     = cnt_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl: a stall-budget model checks every cycle,
// and hand-computed literals pin key points of each scenario.
module tb_branch_resolve_ctrl;

  localparam int XLEN    = 32;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [6:0] BR_OP = 7'b1100011;

  logic             clk;
  logic             rst, hold, kill;
  logic             id_valid;
  logic [6:0]       id_opcode;
  logic [4:0]       id_rs1, id_rs2;
  logic [XLEN-1:0]  id_pc, id_imm;
  logic             ex_reg_write, ex_mem_read;
  logic [4:0]       ex_rd;
  logic             mem_mem_read;
  logic [4:0]       mem_rd;
  logic             branch_taken;
  logic             stall_front, bubble_id_ex, pc_redirect, flush_if_id;
  logic [XLEN-1:0]  branch_target;
  logic [CNT_W-1:0] br_count, taken_count, stall_count;
  logic [1:0]       dbg_state;
  logic             dbg_cnt;

  int n_vec = 0;
  int n_err = 0;

  branch_resolve_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W), .BR_OPCODE(BR_OP)) dut (
    .clk(clk), .rst(rst), .hold(hold), .kill(kill),
    .id_valid(id_valid), .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_pc(id_pc), .id_imm(id_imm),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .mem_mem_read(mem_mem_read), .mem_rd(mem_rd), .branch_taken(branch_taken),
    .stall_front(stall_front), .bubble_id_ex(bubble_id_ex),
    .pc_redirect(pc_redirect), .flush_if_id(flush_if_id),
    .branch_target(branch_target),
    .br_count(br_count), .taken_count(taken_count), .stall_count(stall_count),
    .dbg_state(dbg_state), .dbg_cnt(dbg_cnt)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: pend = stall cycles still owed before the branch resolves, -1 = no branch in flight.
  int pend = -1;
  int m_br = 0, m_tk = 0, m_st = 0;

  function automatic int need_of(input logic [4:0] r);
    if (r == 5'd0) return 0;
    if (ex_mem_read && ex_rd == r) return 2;
    if ((ex_reg_write && ex_rd == r) || (mem_mem_read && mem_rd == r)) return 1;
    return 0;
  endfunction

  always @(negedge clk) begin
    int  n;
    bit  e_stall, res, e_redir;
    n = 0; e_stall = 0; res = 0;
    if (rst || kill) begin
      // everything forced low
    end else if (pend < 0) begin
      if (id_valid && id_opcode == BR_OP) begin
        n = (need_of(id_rs1) > need_of(id_rs2)) ? need_of(id_rs1) : need_of(id_rs2);
        if (n > 0) e_stall = 1; else res = 1;
      end
    end else if (pend > 0) begin
      e_stall = 1;
    end else begin
      res = 1;
    end
    e_redir = res && branch_taken && !hold;

    chk("stall_front",  {31'd0, stall_front},  {31'd0, e_stall});
    chk("bubble_id_ex", {31'd0, bubble_id_ex}, {31'd0, e_stall});
    chk("pc_redirect",  {31'd0, pc_redirect},  {31'd0, e_redir});
    chk("flush_if_id",  {31'd0, flush_if_id},  {31'd0, e_redir});
    chk("branch_target", branch_target, id_pc + id_imm);
    chk("br_count",    {28'd0, br_count},    m_br);
    chk("taken_count", {28'd0, taken_count}, m_tk);
    chk("stall_count", {28'd0, stall_count}, m_st);

    if (rst) begin
      pend = -1; m_br = 0; m_tk = 0; m_st = 0;
    end else if (kill) begin
      pend = -1;
    end else if (!hold) begin
      if (res) begin
        if (m_br < CNT_MAX) m_br++;
        if (branch_taken && m_tk < CNT_MAX) m_tk++;
        pend = -1;
      end else if (e_stall) begin
        if (m_st < CNT_MAX) m_st++;
        pend = (pend < 0) ? n - 1 : pend - 1;
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic clear_in();
    hold = 0; kill = 0; id_valid = 0; id_opcode = '0; id_rs1 = '0; id_rs2 = '0;
    id_pc = '0; id_imm = '0; ex_reg_write = 0; ex_mem_read = 0; ex_rd = '0;
    mem_mem_read = 0; mem_rd = '0; branch_taken = 0;
  endtask

  task automatic br(input logic [4:0] r1, input logic [4:0] r2, input logic [31:0] pc,
                    input logic [31:0] imm, input logic tk);
    id_valid = 1; id_opcode = BR_OP; id_rs1 = r1; id_rs2 = r2;
    id_pc = pc; id_imm = imm; branch_taken = tk;
  endtask

  task automatic chk_cnt(input string tag, input int b, input int t, input int s);
    chk({tag, "_br"},    {28'd0, br_count},    b);
    chk({tag, "_taken"}, {28'd0, taken_count}, t);
    chk({tag, "_stall"}, {28'd0, stall_count}, s);
  endtask

  initial begin
    clear_in(); rst = 1;
    tick(); tick();
    settle(); chk_cnt("reset", 0, 0, 0);
    chk("reset_stall", {31'd0, stall_front}, 0);

    // BEQ, no hazard: same-cycle redirect
    tick(); rst = 0; br(5'd1, 5'd2, 32'h100, 32'h20, 1);
    settle(); chk("beq_redirect", {31'd0, pc_redirect}, 1);
    chk("beq_flush", {31'd0, flush_if_id}, 1);
    chk("beq_target", branch_target, 32'h120);
    tick(); clear_in();
    settle(); chk_cnt("beq", 1, 1, 0);

    // ALU result in EX -> 1 stall
    tick(); br(5'd5, 5'd6, 32'h140, 32'h10, 0); ex_reg_write = 1; ex_rd = 5'd5;
    settle(); chk("alu_stall", {31'd0, stall_front}, 1);
    chk("alu_bubble", {31'd0, bubble_id_ex}, 1);
    tick(); ex_reg_write = 0; ex_rd = 0; mem_rd = 5'd5;
    settle(); chk("alu_res_stall", {31'd0, stall_front}, 0);
    chk("alu_res_redirect", {31'd0, pc_redirect}, 0);
    tick(); clear_in();
    settle(); chk_cnt("alu", 2, 1, 1);

    // load in EX -> 2 stalls, negative offset
    tick(); br(5'd7, 5'd0, 32'h200, 32'hFFFF_FFF8, 1); ex_mem_read = 1; ex_rd = 5'd7;
    settle(); chk("ld_stall1", {31'd0, stall_front}, 1);
    tick(); ex_mem_read = 0; ex_rd = 0; mem_mem_read = 1; mem_rd = 5'd7;
    settle(); chk("ld_stall2", {31'd0, stall_front}, 1);
    chk("ld_stall2_redirect", {31'd0, pc_redirect}, 0);
    tick(); mem_mem_read = 0; mem_rd = 0;
    settle(); chk("ld_redirect", {31'd0, pc_redirect}, 1);
    chk("ld_target", branch_target, 32'h1F8);
    tick(); clear_in();
    settle(); chk_cnt("ld", 3, 2, 3);

    // x0 never hazards
    tick(); br(5'd0, 5'd0, 32'h300, 32'h40, 0); ex_mem_read = 1; ex_rd = 5'd0;
    settle(); chk("x0_stall", {31'd0, stall_front}, 0);
    tick(); clear_in();
    settle(); chk_cnt("x0", 4, 2, 3);

    // load in MEM on rs2 -> 1 stall
    tick(); br(5'd3, 5'd9, 32'h400, 32'h8, 1); mem_mem_read = 1; mem_rd = 5'd9;
    settle(); chk("lmem_stall", {31'd0, stall_front}, 1);
    tick(); mem_mem_read = 0; mem_rd = 0;
    settle(); chk("lmem_target", branch_target, 32'h408);
    chk("lmem_redirect", {31'd0, pc_redirect}, 1);
    tick(); clear_in();
    settle(); chk_cnt("lmem", 5, 3, 4);

    // non-branch with hazard: nothing happens
    tick(); id_valid = 1; id_opcode = 7'b0110011; id_rs1 = 5'd5; ex_mem_read = 1; ex_rd = 5'd5;
    settle(); chk("nonbr_stall", {31'd0, stall_front}, 0);
    tick(); clear_in();

    // hold for 3 cycles during STALL
    tick(); br(5'd7, 5'd8, 32'h500, 32'h100, 1); ex_mem_read = 1; ex_rd = 5'd8;
    settle(); chk("hold_pre_stall", {31'd0, stall_front}, 1);
    tick(); ex_mem_read = 0; ex_rd = 0; hold = 1;
    for (int i = 0; i < 3; i++) begin
      settle(); chk("hold_stall", {31'd0, stall_front}, 1);
      chk("hold_redirect", {31'd0, pc_redirect}, 0);
      tick();
    end
    hold = 0;
    settle(); chk("hold_after_stall", {31'd0, stall_front}, 1);
    tick();
    settle(); chk("hold_redirect_final", {31'd0, pc_redirect}, 1);
    chk("hold_target", branch_target, 32'h600);
    tick(); clear_in();
    settle(); chk_cnt("hold", 6, 4, 6);

    // hold during the resolve cycle delays the redirect
    tick(); br(5'd2, 5'd0, 32'h10, 32'h4, 1); ex_reg_write = 1; ex_rd = 5'd2;
    settle(); chk("hres_stall", {31'd0, stall_front}, 1);
    tick(); ex_reg_write = 0; ex_rd = 0; hold = 1;
    settle(); chk("hres_redirect_held", {31'd0, pc_redirect}, 0);
    tick(); hold = 0;
    settle(); chk("hres_redirect", {31'd0, pc_redirect}, 1);
    tick(); clear_in();
    settle(); chk_cnt("hres", 7, 5, 7);

    // kill in STALL
    tick(); br(5'd7, 5'd0, 32'h700, 32'h10, 1); ex_mem_read = 1; ex_rd = 5'd7;
    settle(); chk("kill_pre_stall", {31'd0, stall_front}, 1);
    tick(); ex_mem_read = 0; ex_rd = 0; kill = 1;
    settle(); chk("kill_stall", {31'd0, stall_front}, 0);
    chk("kill_redirect", {31'd0, pc_redirect}, 0);
    tick(); kill = 0; id_valid = 0;
    settle(); chk("kill_after_stall", {31'd0, stall_front}, 0);
    chk_cnt("kill", 7, 5, 8);

    // reset mid-stall
    tick(); br(5'd7, 5'd0, 32'h800, 32'h10, 1); ex_mem_read = 1; ex_rd = 5'd7;
    settle(); chk("rst_pre_stall", {31'd0, stall_front}, 1);
    tick(); ex_mem_read = 0; ex_rd = 0; rst = 1;
    settle(); chk("rst_mid_stall", {31'd0, stall_front}, 0);
    chk("rst_mid_bubble", {31'd0, bubble_id_ex}, 0);
    tick();
    settle(); chk_cnt("rst_mid", 0, 0, 0);
    tick(); rst = 0; clear_in();

    // saturation: 17 one-stall taken branches on a 4-bit counter
    for (int i = 0; i < 17; i++) begin
      tick(); br(5'd4, 5'd0, 32'h900 + 32'(i * 4), 32'h20, 1); ex_reg_write = 1; ex_rd = 5'd4;
      tick(); ex_reg_write = 0; ex_rd = 0;
    end
    tick(); clear_in();
    settle(); chk_cnt("sat", 15, 15, 15);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
- Sequences ID-stage branch resolution around the ID-stage branch comparator.
- Detects RAW hazards on a branch's rs1/rs2 against instructions in EX/MEM and stalls the front end for the required cycles.
- When the comparator's result is valid, issues the PC redirect and IF/ID flush.
- Keeps saturating branch and stall statistics counters.

Parameters:
XLEN, 32, width of PC/immediate/target
CNT_W, 32, width of statistics counters
BR_OPCODE, 7'b1100011, opcode value treated as conditional branch

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
hold  in  1  global pipeline freeze (e.g. memory wait); FSM and counters hold
kill  in  1  higher-priority flush (exception/redirect from later stage)
id_valid  in  1  ID stage holds a valid instruction
id_opcode  in  7  ID instruction opcode
id_rs1  in  5  ID source register 1
id_rs2  in  5  ID source register 2
id_pc  in  XLEN  PC of ID instruction
id_imm  in  XLEN  sign-extended B-type immediate
ex_reg_write  in  1  EX instruction writes rd
ex_mem_read  in  1  EX instruction is a load
ex_rd  in  5  EX destination
mem_mem_read  in  1  MEM instruction is a load
mem_rd  in  5  MEM destination
branch_taken  in  1  comparator result for ID instruction
stall_front  out  1  hold PC and IF/ID register
bubble_id_ex  out  1  insert NOP into ID/EX
pc_redirect  out  1  select branch target as next PC
flush_if_id  out  1  squash IF/ID contents
branch_target  out  XLEN  id_pc + id_imm, modulo 2^XLEN
br_count  out  CNT_W  resolved branches
taken_count  out  CNT_W  resolved taken branches
stall_count  out  CNT_W  branch stall cycles

Behaviour:
- is_br = id_valid & (id_opcode == BR_OPCODE).
- Hazard on register r (r != 0):
  - load_ex = ex_mem_read & ex_rd == r; needs 2 stall cycles.
  - alu_ex = ex_reg_write & !ex_mem_read & ex_rd == r; needs 1 stall cycle.
  - load_mem = mem_mem_read & mem_rd == r; needs 1 stall cycle.
- N = max over rs1, rs2 of the required stall cycles (0, 1 or 2).
- FSM states: IDLE, STALL, RESOLVE; reset state IDLE; 1-bit stall counter cnt, reset 0.
- IDLE:
  - If is_br & N>0: stall_front=1, bubble_id_ex=1. Next state is STALL with cnt=0 when N=2, else RESOLVE.
  - If is_br & N==0: resolve this cycle (see below); stay in IDLE.
- STALL: stall_front=1, bubble_id_ex=1; next state RESOLVE. No hazard re-check in this state.
- RESOLVE: no hazard check; comparator operands are valid via forwarding. Resolve, then go to IDLE.
- Resolve cycle:
  - pc_redirect = flush_if_id = branch_taken.
  - br_count increments by 1; taken_count increments by 1 if branch_taken.
- stall_count increments in every cycle where stall_front=1.
- All counters saturate at all-ones.
- stall_front, bubble_id_ex, pc_redirect and flush_if_id are combinational from state and inputs (same-cycle PC mux); all are 0 unless stated above.
- branch_target is always driven combinationally.
- hold=1:
  - State, cnt and counters frozen.
  - pc_redirect and flush_if_id forced 0.
  - stall_front and bubble_id_ex keep their state-derived values.
  - No resolution is counted.
- kill=1 (priority over hold and over all FSM activity):
  - Next state IDLE, cnt=0.
  - All four control outputs 0 that cycle.
  - No counter updates.
- rst=1: state IDLE, cnt 0, all counters 0. Outputs 0 except branch_target; holds mid-stall as well.
- Non-branch in ID in IDLE: outputs 0, no counting.

Test Plan:
- BEQ x1,x2 with x1==x2, no hazards, id_pc=0x100, id_imm=0x20 -> same cycle pc_redirect=1, flush_if_id=1, branch_target=0x120; br_count=1, taken_count=1.
- ADD x5 in EX, then BNE x5,x6 in ID -> exactly 1 cycle stall_front/bubble_id_ex, then RESOLVE cycle uses branch_taken; stall_count=1.
- LW x7 in EX, then BLT x7,x0 in ID -> 2 stall cycles (IDLE, STALL) then RESOLVE; stall_count=2. Repeat with ex_rd=0 -> no stall.
- hold=1 asserted during STALL for 3 cycles -> state frozen, stall_front stays 1, pc_redirect=0; resumes and resolves after hold drops; stall_count increments only on non-hold stall cycles.
- kill=1 in STALL -> next cycle IDLE, no redirect, br_count unchanged. Separately, rst=1 mid-stall -> all outputs and counters 0.
- Force br_count to all-ones (run 2^CNT_W-1 branches with small CNT_W=4, i.e. 15) -> count holds at 15 after a further branch.
